counter_param_gray: RTL and testbench



---
 rtl/counter_pkg.sv | 26 ++
 rtl/gray_encode.sv | 12 +
 rtl/counter_param_gray.sv | 41 ++++
 tb/tb_counter_param_gray.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the Gray-code counter and related CDC helpers.
package counter_pkg;

    localparam int COUNTER_W_DEFAULT = 8;

    // Functions work on a fixed 32-bit container. Zero-extending a narrower
    // value gives the correct N-bit result, because the leading zeros do not
    // change the lower bits in either direction of the conversion.
    localparam int GRAY_FN_W = 32;

    // Binary to reflected Gray code. This matches gray_encode.
    function automatic logic [GRAY_FN_W-1:0] bin_to_gray(input logic [GRAY_FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary, using a prefix XOR that runs from the MSB down.
    function automatic logic [GRAY_FN_W-1:0] gray_to_bin(input logic [GRAY_FN_W-1:0] gray);
        logic [GRAY_FN_W-1:0] bin;
        bin[GRAY_FN_W-1] = gray[GRAY_FN_W-1];
        for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Purely combinational binary-to-reflected-Gray encoder. Other CDC blocks can reuse it.
module gray_encode #(
    parameter int N = 8
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    // Shifting right fills the MSB with zero, so gray[N-1] == bin[N-1].
    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/counter_param_gray.sv
// Free-running N-bit Gray-code counter with a registered output.
// A binary register holds the count. Its successor is Gray-encoded and
// registered, so count_out leaves a flip-flop and has no
// combinational path from any input.
module counter_param_gray
    import counter_pkg::*;
#(
    parameter int N = COUNTER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_al_in,
    output logic [N-1:0] count_out
);

    logic [N-1:0] r_bin;
    logic [N-1:0] w_bin_next;
    logic [N-1:0] w_gray_next;

    // Modulo-2^N incrementer. Overflow wraps naturally at N bits.
    assign w_bin_next = r_bin + {{(N-1){1'b0}}, 1'b1};

    gray_encode #(
        .N (N)
    ) u_gray_encode (
        .bin  (w_bin_next),
        .gray (w_gray_next)
    );

    // Binary and Gray registers advance together, which keeps count_out == gray(r_bin).
    // Reset clears both asynchronously and wins over a simultaneous clock edge.
    always_ff @(posedge clk or posedge reset_al_in) begin
        if (reset_al_in) begin
            r_bin     <= '0;
            count_out <= '0;
        end else begin
            r_bin     <= w_bin_next;
            count_out <= w_gray_next;
        end
    end

endmodule

// File: tb/tb_counter_param_gray.sv
// Self-checking bench for counter_param_gray at N = 8 and N = 4.
// Both instances share the clock and reset.
module tb_counter_param_gray;

    logic       clk;
    logic       rst;
    logic [7:0] count8;
    logic [3:0] count4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] g8;
        logic [3:0] g4;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m8;
    logic [3:0] m4;
    logic [7:0] prev8;
    logic [3:0] prev4;
    bit         seen[256];

    counter_param_gray #(.N(8)) dut8 (
        .clk         (clk),
        .reset_al_in (rst),
        .count_out   (count8)
    );

    counter_param_gray #(.N(4)) dut4 (
        .clk         (clk),
        .reset_al_in (rst),
        .count_out   (count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [3:0] g2b4(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m8    = 8'd0;
        m4    = 4'd0;
        prev8 = 8'd0;
        prev4 = 4'd0;
    endtask

    // One clock edge: push the model's expectation, then compare after the edge.
    task automatic tick();
        exp_t       e;
        logic [7:0] inc8;
        logic [3:0] inc4;
        m8   = m8 + 8'd1;
        m4   = m4 + 4'd1;
        e.g8 = m8 ^ (m8 >> 1);
        e.g4 = m4 ^ (m4 >> 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("seq8", 32'(count8), 32'(e.g8));
        chk("seq4", 32'(count4), 32'(e.g4));
        chk("ham8", 32'($countones(count8 ^ prev8)), 32'd1);
        chk("ham4", 32'($countones(count4 ^ prev4)), 32'd1);
        inc8 = g2b8(prev8) + 8'd1;
        inc4 = g2b4(prev4) + 4'd1;
        chk("dec8", 32'(g2b8(count8)), 32'(inc8));
        chk("dec4", 32'(g2b4(count4)), 32'(inc4));
        prev8 = count8;
        prev4 = count4;
    endtask

    initial begin
        logic [7:0] startup [4];
        int         nseen;
        startup[0] = 8'b00000001;
        startup[1] = 8'b00000011;
        startup[2] = 8'b00000010;
        startup[3] = 8'b00000110;

        // Hold reset across several edges.
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold8", 32'(count8), 32'd0);
            chk("rst_hold4", 32'(count4), 32'd0);
        end

        // Release reset, then run an exhaustive pass plus wrap on N=8.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int e = 1; e <= 257; e++) begin
            tick();
            if (e <= 4) chk("startup8", 32'(count8), 32'(startup[e-1]));
            if (e <= 256) begin
                chk("distinct8", 32'(seen[count8]), 32'd0);
                seen[count8] = 1'b1;
            end
            if (e == 255) chk("wrap255", 32'(count8), 32'h80);
            if (e == 256) chk("wrap256", 32'(count8), 32'h00);
            if (e == 257) chk("wrap257", 32'(count8), 32'h01);
            if (e == 4)   chk("n4_e4",  32'(count4), 32'h6);
            if (e == 8)   chk("n4_e8",  32'(count4), 32'hC);
            if (e == 15)  chk("n4_e15", 32'(count4), 32'h8);
            if (e == 16)  chk("n4_e16", 32'(count4), 32'h0);
        end
        nseen = 0;
        for (int i = 0; i < 256; i++) nseen += int'(seen[i]);
        chk("all_codes8", 32'(nseen), 32'd256);

        // Asynchronous reset between edges clears the count before the next edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_clr8", 32'(count8), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_b8", 32'(count8), 32'd0);
            chk("rst_hold_b4", 32'(count4), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Mid-run reset after 47 edges.
        for (int e = 1; e <= 47; e++) tick();
        chk("gray47", 32'(count8), 32'h38);
        #3;
        rst = 1'b1;
        #1;
        chk("midrun_clr8", 32'(count8), 32'd0);
        chk("midrun_clr4", 32'(count4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
        chk("restart8", 32'(count8), 32'h01);
        chk("restart4", 32'(count4), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
